vga_ram_arbiter: RTL and testbench



---
 rtl/vga_ram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_vga_ram_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ram_arbiter.sv
// -----------------------------------------------------------------------------
// vga_ram_arbiter
//
// Shares one single-ported, registered-read pixel RAM between a VGA scanout
// reader and a CPU. VGA normally wins every cycle it asks. A CPU request that
// has waited STARVE_LIMIT cycles is forced through, which drops that cycle's
// VGA request.
//
// Ports
//   clk, reset_n                  single clock, asynchronous active-low reset
//   vga_req, vga_addr             scanout read request, one word per cycle
//   vga_valid, vga_data           read word for the request granted last cycle
//   vga_drop, drop_count          preemption pulse and saturating drop counter
//   cpu_req, cpu_we, cpu_addr,    CPU access; request held until cpu_ack
//   cpu_wdata
//   cpu_ack, cpu_rdata            completion pulse and registered read data
//   ram_wEn, ram_addr,            RAM control, combinational from the grant
//   ram_dataIn
//   ram_dataOut                   RAM read data, one-cycle latency
// -----------------------------------------------------------------------------
module vga_ram_arbiter #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 19,
   parameter int unsigned STARVE_LIMIT  = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,

   input  logic                     vga_req,
   input  logic [ADDRESS_WIDTH-1:0] vga_addr,
   output logic                     vga_valid,
   output logic [DATA_WIDTH-1:0]    vga_data,
   output logic                     vga_drop,
   output logic [15:0]              drop_count,

   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   output logic                     cpu_ack,
   output logic [DATA_WIDTH-1:0]    cpu_rdata,

   output logic                     ram_wEn,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_dataIn,
   input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

   // Wide enough to hold STARVE_LIMIT; at least one bit so a zero limit still builds.
   localparam int unsigned WaitW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_LIMIT);

   typedef enum logic [0:0] {
      StIdle,
      StRdCapture
   } state_e;

   state_e                  state_q, state_d;
   logic [WaitW-1:0]        wait_cnt_q, wait_cnt_d;
   logic                    vga_valid_q;
   logic                    vga_drop_q;
   logic [15:0]             drop_count_q, drop_count_d;
   logic                    cpu_ack_q, cpu_ack_d;
   logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;

   logic                    force_cpu;
   logic                    grant_vga;
   logic                    grant_cpu;
   logic                    drop_now;

   // ---------------------------------------------------------------------------
   // Grant
   // ---------------------------------------------------------------------------
   always_comb begin
      force_cpu = (wait_cnt_q == WaitMax) && (state_q == StIdle);
      grant_vga = vga_req && !force_cpu;
      // cpu_ack high means the held request was just served; do not serve it twice.
      grant_cpu = !grant_vga && cpu_req && (state_q == StIdle) && !cpu_ack_q;
      // Any VGA request refused because of the force flag counts as a drop.
      drop_now  = vga_req && force_cpu;
   end

   // ---------------------------------------------------------------------------
   // RAM port drive
   // ---------------------------------------------------------------------------
   always_comb begin
      ram_addr   = vga_addr;
      ram_wEn    = 1'b0;
      ram_dataIn = '0;
      if (grant_cpu) begin
         ram_addr   = cpu_addr;
         // Gated by reset so the RAM can never be written while the block is held.
         ram_wEn    = cpu_we && reset_n;
         ram_dataIn = cpu_wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // CPU access FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cpu_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (grant_cpu) begin
               if (cpu_we) begin
                  cpu_ack_d = 1'b1;
               end else begin
                  state_d = StRdCapture;
               end
            end
         end
         StRdCapture: begin
            // ram_dataOut now holds the word addressed in the grant cycle; a VGA
            // grant in this cycle only changes it after the coming edge.
            cpu_rdata_d = ram_dataOut;
            cpu_ack_d   = 1'b1;
            state_d     = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Starvation counter and drop counter
   // ---------------------------------------------------------------------------
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!cpu_req || grant_cpu) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WaitMax) begin
         wait_cnt_d = wait_cnt_q + WaitW'(1);
      end
   end

   always_comb begin
      drop_count_d = drop_count_q;
      if (drop_now && (drop_count_q != 16'hFFFF)) begin
         drop_count_d = drop_count_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         wait_cnt_q   <= '0;
         vga_valid_q  <= 1'b0;
         vga_drop_q   <= 1'b0;
         drop_count_q <= 16'd0;
         cpu_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         vga_valid_q  <= grant_vga;
         vga_drop_q   <= drop_now;
         drop_count_q <= drop_count_d;
         cpu_ack_q    <= cpu_ack_d;
         cpu_rdata_q  <= cpu_rdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign vga_valid  = vga_valid_q;
   assign vga_data   = ram_dataOut;
   assign vga_drop   = vga_drop_q;
   assign drop_count = drop_count_q;
   assign cpu_ack    = cpu_ack_q;
   assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_ram_arbiter
//
// Bench for vga_ram_arbiter with a behavioural registered-read RAM. VGA words
// and CPU completions are predicted into queues as stimulus is driven and
// retired by a negedge monitor. A second instance with STARVE_LIMIT = 0 drops
// a VGA request every cycle and is used to reach drop counter saturation.
// -----------------------------------------------------------------------------
module tb_vga_ram_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 19;
   localparam int unsigned SL = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          vga_req;
   logic [AW-1:0] vga_addr;
   logic          vga_valid;
   logic [DW-1:0] vga_data;
   logic          vga_drop;
   logic [15:0]   drop_count;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          ram_wEn;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dataIn;
   logic [DW-1:0] ram_dataOut;

   vga_ram_arbiter #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .STARVE_LIMIT  (SL)
   ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .vga_valid   (vga_valid),
      .vga_data    (vga_data),
      .vga_drop    (vga_drop),
      .drop_count  (drop_count),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .ram_wEn     (ram_wEn),
      .ram_addr    (ram_addr),
      .ram_dataIn  (ram_dataIn),
      .ram_dataOut (ram_dataOut)
   );

   // Saturation instance: force is permanently set, so every VGA request drops.
   logic          s_vga_req;
   logic          s_vga_valid;
   logic [DW-1:0] s_vga_data;
   logic          s_vga_drop;
   logic [15:0]   s_drop_count;
   logic          s_cpu_req;
   logic          s_cpu_ack;
   logic [DW-1:0] s_cpu_rdata;
   logic          s_ram_wEn;
   logic [AW-1:0] s_ram_addr;
   logic [DW-1:0] s_ram_dataIn;
   logic [DW-1:0] s_ram_dataOut;
   assign s_ram_dataOut = '0;

   vga_ram_arbiter #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .STARVE_LIMIT  (0)
   ) u_sat (
      .clk         (clk),
      .reset_n     (reset_n),
      .vga_req     (s_vga_req),
      .vga_addr    (19'h00100),
      .vga_valid   (s_vga_valid),
      .vga_data    (s_vga_data),
      .vga_drop    (s_vga_drop),
      .drop_count  (s_drop_count),
      .cpu_req     (s_cpu_req),
      .cpu_we      (1'b1),
      .cpu_addr    (19'h00200),
      .cpu_wdata   (8'h5A),
      .cpu_ack     (s_cpu_ack),
      .cpu_rdata   (s_cpu_rdata),
      .ram_wEn     (s_ram_wEn),
      .ram_addr    (s_ram_addr),
      .ram_dataIn  (s_ram_dataIn),
      .ram_dataOut (s_ram_dataOut)
   );

   // Behavioural RAM: write when enabled, otherwise registered read.
   logic [DW-1:0] mem [0:(2**AW)-1];
   always @(posedge clk) begin
      if (ram_wEn) mem[ram_addr] <= ram_dataIn;
      else         ram_dataOut   <= mem[ram_addr];
   end

   // Expected RAM contents, built from the writes the bench issues.
   logic [DW-1:0] shadow [logic [AW-1:0]];

   logic [DW-1:0] vga_exp_q [$];
   logic          cpu_rd_q  [$];
   logic [DW-1:0] cpu_dat_q [$];

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor.
   logic [DW-1:0] mon_d;
   logic          mon_rd;
   always @(negedge clk) begin
      if (reset_n) begin
         if (vga_valid) begin
            if (vga_exp_q.size() == 0) begin
               check_eq("vga_spurious_valid", 32'(vga_valid), 0);
            end else begin
               mon_d = vga_exp_q.pop_front();
               check_eq("vga_data", 32'(vga_data), 32'(mon_d));
            end
         end
         if (cpu_ack) begin
            if (cpu_rd_q.size() == 0) begin
               check_eq("cpu_spurious_ack", 32'(cpu_ack), 0);
            end else begin
               mon_rd = cpu_rd_q.pop_front();
               mon_d  = cpu_dat_q.pop_front();
               if (mon_rd) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(mon_d));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!cpu_ack && lat < 40);
      if (!cpu_ack) check_eq("cpu_ack_timeout", 32'(cpu_ack), 1);
   endtask

   task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      shadow[a] = d;
      cpu_rd_q.push_back(1'b0); cpu_dat_q.push_back(d);
      wait_ack(lat);
      cpu_req = 1'b0; cpu_we = 1'b0;
   endtask

   task automatic cpu_read(input logic [AW-1:0] a, output int lat);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      cpu_rd_q.push_back(1'b1); cpu_dat_q.push_back(shadow[a]);
      wait_ack(lat);
      cpu_req = 1'b0;
   endtask

   initial begin
      int lat;
      reset_n = 1'b0;
      vga_req = 1'b0; vga_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      s_vga_req = 1'b0; s_cpu_req = 1'b0;
      repeat (2) tick();

      // Reset values; a write request during reset must not reach the RAM.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00010; cpu_wdata = 8'hFF;
      #1;
      check_eq("rst_ram_wen", 32'(ram_wEn), 0);
      check_eq("rst_vga_valid", 32'(vga_valid), 0);
      check_eq("rst_vga_drop", 32'(vga_drop), 0);
      check_eq("rst_drop_count", 32'(drop_count), 0);
      check_eq("rst_cpu_ack", 32'(cpu_ack), 0);
      check_eq("rst_cpu_rdata", 32'(cpu_rdata), 0);
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      // CPU write 0xA5 to 0x10: same-cycle write enable, ack next cycle.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00010; cpu_wdata = 8'hA5;
      shadow[19'h00010] = 8'hA5;
      cpu_rd_q.push_back(1'b0); cpu_dat_q.push_back(8'hA5);
      #1;
      check_eq("wr_ram_wen", 32'(ram_wEn), 1);
      check_eq("wr_ram_addr", 32'(ram_addr), 'h10);
      check_eq("wr_ram_din", 32'(ram_dataIn), 'hA5);
      check_eq("wr_ack_early", 32'(cpu_ack), 0);
      tick();
      check_eq("wr_ack", 32'(cpu_ack), 1);
      check_eq("wr_no_regrant", 32'(ram_wEn), 0);
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
      check_eq("wr_ack_pulse", 32'(cpu_ack), 0);

      // VGA read-back of 0x10.
      vga_req = 1'b1; vga_addr = 19'h00010;
      vga_exp_q.push_back(shadow[19'h00010]);
      #1;
      check_eq("vga_ram_addr", 32'(ram_addr), 'h10);
      check_eq("vga_ram_wen", 32'(ram_wEn), 0);
      tick();
      vga_req = 1'b0;
      check_eq("vga_valid_1", 32'(vga_valid), 1);
      tick();
      check_eq("vga_valid_0", 32'(vga_valid), 0);

      // Block of random writes, then a back-to-back VGA burst over them.
      for (int i = 0; i < 6; i++) cpu_write(AW'(32'h20 + i), DW'($urandom), lat);
      for (int i = 0; i < 6; i++) begin
         vga_req = 1'b1; vga_addr = AW'(32'h20 + i);
         vga_exp_q.push_back(shadow[vga_addr]);
         tick();
      end
      vga_req = 1'b0;
      repeat (2) tick();

      // CPU read of 0x10 with vga_req toggling.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
      cpu_rd_q.push_back(1'b1); cpu_dat_q.push_back(8'hA5);
      #1;
      check_eq("rd_ram_addr", 32'(ram_addr), 'h10);
      check_eq("rd_ram_wen", 32'(ram_wEn), 0);
      tick();
      vga_req = 1'b1; vga_addr = 19'h00021;
      vga_exp_q.push_back(shadow[19'h00021]);
      #1;
      check_eq("rd_capture_ack", 32'(cpu_ack), 0);
      check_eq("rd_capture_vga", 32'(ram_addr), 'h21);
      tick();
      vga_req = 1'b0;
      check_eq("rd_ack", 32'(cpu_ack), 1);
      check_eq("rd_data", 32'(cpu_rdata), 'hA5);
      cpu_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         vga_req = (k % 2 == 0); vga_addr = AW'(32'h22 + k);
         if (vga_req) vga_exp_q.push_back(shadow[vga_addr]);
         check_eq("rd_data_hold", 32'(cpu_rdata), 'hA5);
         check_eq("rd_ack_once", 32'(cpu_ack), 0);
      end
      tick();
      vga_req = 1'b0;
      tick();

      // Starvation: VGA wins 8 cycles, CPU forced on the 9th, twice in a row.
      for (int r = 1; r <= 2; r++) begin
         vga_req = 1'b1; vga_addr = 19'h00010;
         cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00030;
         cpu_wdata = (r == 1) ? 8'hC3 : 8'h3C;
         shadow[19'h00030] = cpu_wdata;
         cpu_rd_q.push_back(1'b0); cpu_dat_q.push_back(cpu_wdata);
         for (int c = 1; c <= 9; c++) begin
            #1;
            check_eq("starve_ack_low", 32'(cpu_ack), 0);
            check_eq("starve_no_drop", 32'(vga_drop), 0);
            if (c < 9) begin
               check_eq("starve_vga_wins", 32'(ram_addr), 'h10);
               check_eq("starve_vga_wen", 32'(ram_wEn), 0);
               vga_exp_q.push_back(shadow[19'h00010]);
            end else begin
               check_eq("starve_force_wen", 32'(ram_wEn), 1);
               check_eq("starve_force_addr", 32'(ram_addr), 'h30);
            end
            tick();
         end
         cpu_req = 1'b0; cpu_we = 1'b0;
         #1;
         check_eq("force_ack", 32'(cpu_ack), 1);
         check_eq("force_drop", 32'(vga_drop), 1);
         check_eq("force_valid_low", 32'(vga_valid), 0);
         check_eq("force_drop_count", 32'(drop_count), r);
         check_eq("post_force_vga", 32'(ram_addr), 'h10);
         vga_exp_q.push_back(shadow[19'h00010]);
         tick();
         check_eq("drop_pulse_end", 32'(vga_drop), 0);
         check_eq("drop_count_hold", 32'(drop_count), r);
         check_eq("post_force_valid", 32'(vga_valid), 1);
      end
      vga_req = 1'b0;
      repeat (2) tick();

      // Reset asserted in RD_CAPTURE: outputs clear at once, no ack later.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00030;
      #1;
      check_eq("rstrd_grant", 32'(ram_addr), 'h30);
      tick();
      #1;
      reset_n = 1'b0;
      #1;
      check_eq("rstrd_ack", 32'(cpu_ack), 0);
      check_eq("rstrd_rdata", 32'(cpu_rdata), 0);
      check_eq("rstrd_drop_count", 32'(drop_count), 0);
      check_eq("rstrd_vga_valid", 32'(vga_valid), 0);
      check_eq("rstrd_wen", 32'(ram_wEn), 0);
      cpu_req = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("rstrd_no_ack", 32'(cpu_ack), 0);
      end
      cpu_read(19'h00030, lat);
      check_eq("fresh_rd_latency", lat, 2);
      tick();
      cpu_write(19'h00040, 8'h77, lat);
      check_eq("fresh_wr_latency", lat, 1);
      tick();
      cpu_read(19'h00040, lat);
      tick();

      // Drop counter saturation on the zero-limit instance.
      s_vga_req = 1'b1; s_cpu_req = 1'b1;
      repeat (100) tick();
      check_eq("sat_count_100", 32'(s_drop_count), 100);
      repeat (65434) tick();
      check_eq("sat_count_fffe", 32'(s_drop_count), 'hFFFE);
      tick();
      check_eq("sat_count_ffff", 32'(s_drop_count), 'hFFFF);
      repeat (2) tick();
      check_eq("sat_count_65537", 32'(s_drop_count), 'hFFFF);
      check_eq("sat_still_dropping", 32'(s_vga_drop), 1);
      repeat (50) tick();
      check_eq("sat_count_held", 32'(s_drop_count), 'hFFFF);
      check_eq("sat_valid_low", 32'(s_vga_valid), 0);
      s_vga_req = 1'b0; s_cpu_req = 1'b0;
      repeat (2) tick();
      check_eq("sat_drop_clear", 32'(s_vga_drop), 0);

      repeat (3) tick();
      check_eq("vga_queue_empty", vga_exp_q.size(), 0);
      check_eq("cpu_queue_empty", cpu_rd_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
